sr_cmd_debounce: RTL and testbench



---
 rtl/sr_cmd_debounce.sv | 90 +++++++++
 tb/tb_sr_cmd_debounce.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_debounce.sv
// Command front end for SR flip-flops: synchronises and debounces raw set/clear
// request lines and emits mutually exclusive single-cycle S / R pulses.
module sr_cmd_debounce #(
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic SET_IN,
    input  logic RST_IN,
    output logic S,
    output logic R,
    output logic SET_LVL,
    output logic RST_LVL,
    output logic CONFLICT
);

    // Channel index 0 is the set request, index 1 the clear request.
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES - 1);

    logic [1:0]            raw;
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            lvl_q, lvl_d;
    logic [1:0]            lvl_dly_q, lvl_dly_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            rise;
    logic                  s_q, s_d;
    logic                  r_q, r_d;
    logic                  conflict_q, conflict_d;

    // NOTE: every combinational output is assigned a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        raw       = {RST_IN, SET_IN};
        sync1_d   = raw;
        sync2_d   = sync1_q;
        lvl_dly_d = lvl_q;
        lvl_d     = lvl_q;
        cnt_d     = '0;

        for (int ch = 0; ch < 2; ch++) begin
            if (sync2_q[ch] != lvl_q[ch]) begin
                if (cnt_q[ch] == DB_MAX) begin
                    lvl_d[ch] = sync2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end

        // Only presses produce pulses; on a simultaneous press clear wins and
        // the set request is dropped, so S and R can never both be high.
        rise       = lvl_q & ~lvl_dly_q;
        s_d        = rise[0] & ~rise[1];
        r_d        = rise[1];
        conflict_d = rise[0] & rise[1];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, matching real hardware.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_dly_q  <= '0;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            lvl_dly_q  <= lvl_dly_d;
            cnt_q      <= cnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign CONFLICT = conflict_q;
    assign SET_LVL  = lvl_q[0];
    assign RST_LVL  = lvl_q[1];

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Bench for sr_cmd_debounce: directed scenarios plus a random phase, all
// compared every cycle against a window-based reference model.
module tb_sr_cmd_debounce;

    localparam int DB = 4;

    typedef bit bq_t[$];

    logic CLK = 1'b0;
    logic CLR_N;
    logic set_in, rst_in;
    logic S, R, SET_LVL, RST_LVL, CONFLICT;

    int tests = 0;
    int fails = 0;

    // Reference model state: raw samples per edge, debounced levels, pending rises.
    bq_t hq0, hq1;
    bit  m_lvl0, m_lvl1, m_rise0, m_rise1;
    bit  m_s, m_r, m_c;

    // Per-scenario observations, edges counted from the last mark().
    int edge_idx;
    int s_first, r_first, c_first;
    int s_cnt, r_cnt, c_cnt;
    int setlvl_up, setlvl_dn;
    logic prev_setlvl;

    sr_cmd_debounce #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .CLK      (CLK),
        .CLR_N    (CLR_N),
        .SET_IN   (set_in),
        .RST_IN   (rst_in),
        .S        (S),
        .R        (R),
        .SET_LVL  (SET_LVL),
        .RST_LVL  (RST_LVL),
        .CONFLICT (CONFLICT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        hq0.delete();
        hq1.delete();
        repeat (DB + 2) begin
            hq0.push_back(1'b0);
            hq1.push_back(1'b0);
        end
        m_lvl0 = 0; m_lvl1 = 0; m_rise0 = 0; m_rise1 = 0;
        m_s = 0; m_r = 0; m_c = 0;
    endfunction

    // The level flips once the synchronised input (raw delayed two edges) has
    // differed from it for DB consecutive edges.
    function automatic bit flips(input bq_t q, input bit lvl);
        int sz = q.size();
        for (int k = 0; k < DB; k++)
            if (q[sz - 3 - k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge(input bit raw_set, input bit raw_rst);
        bit n0, n1;
        m_s = m_rise0 & ~m_rise1;
        m_r = m_rise1;
        m_c = m_rise0 & m_rise1;
        hq0.push_back(raw_set);
        hq1.push_back(raw_rst);
        n0 = flips(hq0, m_lvl0) ? ~m_lvl0 : m_lvl0;
        n1 = flips(hq1, m_lvl1) ? ~m_lvl1 : m_lvl1;
        m_rise0 = n0 & ~m_lvl0;
        m_rise1 = n1 & ~m_lvl1;
        m_lvl0 = n0;
        m_lvl1 = n1;
        while (hq0.size() > DB + 2) void'(hq0.pop_front());
        while (hq1.size() > DB + 2) void'(hq1.pop_front());
    endfunction

    task automatic check_outputs();
        check("S", S, m_s);
        check("R", R, m_r);
        check("CONFLICT", CONFLICT, m_c);
        check("SET_LVL", SET_LVL, m_lvl0);
        check("RST_LVL", RST_LVL, m_lvl1);
        check("S_and_R", S & R, 0);
    endtask

    task automatic mark();
        edge_idx = 0;
        s_first = -1; r_first = -1; c_first = -1;
        s_cnt = 0; r_cnt = 0; c_cnt = 0;
        setlvl_up = -1; setlvl_dn = -1;
        prev_setlvl = SET_LVL;
    endtask

    task automatic step();
        @(posedge CLK);
        if (!CLR_N) model_reset();
        else        model_edge(set_in, rst_in);
        #1;
        edge_idx++;
        check_outputs();
        if (S)        begin s_cnt++; if (s_first < 0) s_first = edge_idx; end
        if (R)        begin r_cnt++; if (r_first < 0) r_first = edge_idx; end
        if (CONFLICT) begin c_cnt++; if (c_first < 0) c_first = edge_idx; end
        if (SET_LVL && !prev_setlvl && setlvl_up < 0) setlvl_up = edge_idx;
        if (!SET_LVL && prev_setlvl && setlvl_dn < 0) setlvl_dn = edge_idx;
        prev_setlvl = SET_LVL;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int rel;
        CLR_N  = 1'b0;
        set_in = 1'b0;
        rst_in = 1'b0;
        model_reset();
        #2;
        check("reset_S", S, 0);
        check("reset_R", R, 0);
        check("reset_CONFLICT", CONFLICT, 0);
        check("reset_SET_LVL", SET_LVL, 0);
        check("reset_RST_LVL", RST_LVL, 0);
        run(3);
        CLR_N = 1'b1;
        run(3);

        // Single press held: level after edge 6, one S pulse at edge 7.
        set_in = 1'b1;
        mark();
        run(14);
        check("press_setlvl_edge", setlvl_up, DB + 2);
        check("press_s_edge", s_first, DB + 3);
        check("press_s_count", s_cnt, 1);
        check("press_r_count", r_cnt, 0);
        check("press_conflict_count", c_cnt, 0);
        set_in = 1'b0;
        run(10);

        // Bounce 1,0,1,0 two cycles each, then stable high.
        mark();
        for (int b = 0; b < 4; b++) begin
            set_in = (b % 2 == 0);
            run(2);
        end
        check("bounce_no_s", s_cnt, 0);
        check("bounce_setlvl_low", SET_LVL, 0);
        set_in = 1'b1;
        mark();
        run(12);
        check("bounce_s_edge", s_first, DB + 3);
        check("bounce_s_count", s_cnt, 1);
        set_in = 1'b0;
        run(10);

        // Simultaneous press: clear wins, conflict flagged, no S.
        set_in = 1'b1;
        rst_in = 1'b1;
        mark();
        run(12);
        check("both_r_edge", r_first, DB + 3);
        check("both_conflict_edge", c_first, DB + 3);
        check("both_conflict_count", c_cnt, 1);
        check("both_s_count", s_cnt, 0);
        set_in = 1'b0;
        rst_in = 1'b0;
        run(10);

        // Clear one edge ahead of set: two separate pulses, no conflict.
        rst_in = 1'b1;
        mark();
        step();
        set_in = 1'b1;
        run(12);
        check("stagger_r_edge", r_first, DB + 3);
        check("stagger_s_edge", s_first, DB + 4);
        check("stagger_conflict_count", c_cnt, 0);
        set_in = 1'b0;
        rst_in = 1'b0;
        run(10);

        // Long hold, release, press again: exactly two S pulses.
        set_in = 1'b1;
        mark();
        run(20);
        set_in = 1'b0;
        rel = edge_idx;
        run(12);
        check("release_setlvl_fall", setlvl_dn - rel, DB + 2);
        set_in = 1'b1;
        run(12);
        check("repress_s_count", s_cnt, 2);
        set_in = 1'b0;
        run(10);

        // Reset mid-debounce while the clear level is high.
        rst_in = 1'b1;
        run(10);
        set_in = 1'b1;
        run(4);
        CLR_N  = 1'b0;
        rst_in = 1'b0;
        model_reset();
        #1;
        check("midreset_S", S, 0);
        check("midreset_R", R, 0);
        check("midreset_CONFLICT", CONFLICT, 0);
        check("midreset_SET_LVL", SET_LVL, 0);
        check("midreset_RST_LVL", RST_LVL, 0);
        run(2);
        CLR_N = 1'b1;
        mark();
        run(12);
        check("postreset_s_edge", s_first, DB + 3);
        check("postreset_s_count", s_cnt, 1);
        check("postreset_r_count", r_cnt, 0);
        set_in = 1'b0;
        run(10);

        // Random phase: mixed hold lengths and occasional resets.
        for (int seg = 0; seg < 120; seg++) begin
            set_in = 1'($urandom_range(0, 1));
            rst_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) begin
                CLR_N = 1'b0;
                model_reset();
                #1;
                check_outputs();
                run(1);
                CLR_N = 1'b1;
            end
            run($urandom_range(1, 2 * DB + 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
